// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel framed receiver: start bit 1, WIDTH data bits MSB first, stop bit 0.
// Received words go through a one-entry holding register with a valid/ready handshake.
module sipo_frame_rx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_STOP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic             accept;
  logic             stop_good;
  logic             load;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (si) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == CW'(WIDTH - 1)) state_d = S_STOP;
      S_STOP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and flag logic; a good frame may land in a register being drained this edge
  always_comb begin
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;

    accept    = dout_valid_q & dout_ready;
    stop_good = (state_q == S_STOP) & ~si;
    load      = stop_good & (~dout_valid_q | dout_ready);

    case (state_q)
      S_IDLE: begin
        if (si) cnt_d = '0;
      end
      S_SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], si};
        cnt_d   = cnt_q + CW'(1);
      end
      S_STOP: begin
        frame_err_d = si;
        overrun_d   = stop_good & dout_valid_q & ~dout_ready;
      end
      default: ;
    endcase

    if (load) begin
      dout_d       = shreg_q;
      dout_valid_d = 1'b1;
    end else if (accept) begin
      dout_valid_d = 1'b0;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx: directed scenarios followed by random framed traffic,
// every cycle compared against a frame-level reference model.
module tb_sipo_frame_rx;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         si;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         frame_err;
  logic         overrun;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int           m_pos;
  logic [W-1:0] m_word;
  logic [W-1:0] m_dout;
  logic         m_valid;
  logic         m_fe;
  logic         m_ov;

  sipo_frame_rx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .si         (si),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos   = -1;
    m_word  = '0;
    m_dout  = '0;
    m_valid = 1'b0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
  endtask

  // Frame-level view: m_pos counts bits seen since the start bit, -1 when hunting
  task automatic model_edge(input logic s, input logic r);
    logic load;
    load = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
    if (m_pos < 0) begin
      if (s) begin
        m_pos  = 0;
        m_word = '0;
      end
    end else if (m_pos < int'(W)) begin
      m_word = W'((32'(m_word) * 2 + 32'(s)) % (1 << W));
      m_pos++;
    end else begin
      m_pos = -1;
      if (s) m_fe = 1'b1;
      else if (!m_valid || r) load = 1'b1;
      else m_ov = 1'b1;
    end
    if (load) begin
      m_dout  = m_word;
      m_valid = 1'b1;
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(dout_valid), 32'(m_valid));
    check({tag, ".dout"}, 32'(dout), 32'(m_dout));
    check({tag, ".ferr"}, 32'(frame_err), 32'(m_fe));
    check({tag, ".ovr"}, 32'(overrun), 32'(m_ov));
  endtask

  task automatic step(input logic s, input logic r);
    si         = s;
    dout_ready = r;
    @(posedge clk);
    model_edge(s, r);
    #1;
    check_all("cyc");
  endtask

  function automatic logic pick_rdy(input int mode);
    if (mode == 2) return logic'($urandom_range(0, 1));
    return logic'(mode);
  endfunction

  // rdy modes: 0 / 1 fixed, 2 random per bit
  task automatic send_frame(input logic [W-1:0] w, input logic stop, input int rdy_mode,
                            input int rdy_stop_mode);
    step(1'b1, pick_rdy(rdy_mode));
    for (int i = int'(W) - 1; i >= 0; i--) step(w[i], pick_rdy(rdy_mode));
    step(stop, pick_rdy(rdy_stop_mode));
  endtask

  task automatic zeros_check(input string tag);
    check({tag, ".dout"}, 32'(dout), 32'h0);
    check({tag, ".valid"}, 32'(dout_valid), 32'h0);
    check({tag, ".ferr"}, 32'(frame_err), 32'h0);
    check({tag, ".ovr"}, 32'(overrun), 32'h0);
  endtask

  // Async reset asserted mid-cycle with si toggling, released mid-cycle
  task automatic mid_reset(input string tag);
    #2 rst = 1'b0;
    #1 zeros_check({tag, ".imm"});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      si = ~si;
      #1 zeros_check({tag, ".held"});
    end
    #2;
    rst = 1'b1;
    si  = 1'b0;
    model_reset();
  endtask

  int ferr_seen;
  int ovr_seen;

  initial begin
    rst        = 1'b0;
    si         = 1'b0;
    dout_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 zeros_check("por");
    #3 rst = 1'b1;

    // 1: reset values, then quiet line
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    mid_reset("rst1");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    check("rst1.quiet_valid", 32'(dout_valid), 32'h0);

    // 2: single frame held until accepted
    send_frame(8'hA5, 1'b0, 0, 0);
    check("s2.dout", 32'(dout), 32'hA5);
    check("s2.valid", 32'(dout_valid), 32'h1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    check("s2.held", 32'(dout), 32'hA5);
    step(1'b0, 1'b1);
    check("s2.accepted", 32'(dout_valid), 32'h0);
    step(1'b0, 1'b0);

    // 3: back-to-back with ready held high
    send_frame(8'h3C, 1'b0, 1, 1);
    check("s3.first", 32'(dout), 32'h3C);
    check("s3.first_v", 32'(dout_valid), 32'h1);
    send_frame(8'hFF, 1'b0, 1, 1);
    check("s3.second", 32'(dout), 32'hFF);
    check("s3.second_v", 32'(dout_valid), 32'h1);
    step(1'b0, 1'b1);
    check("s3.drained", 32'(dout_valid), 32'h0);

    // 4: overrun, then simultaneous accept and load
    send_frame(8'h11, 1'b0, 0, 0);
    send_frame(8'h22, 1'b0, 0, 0);
    check("s4.overrun", 32'(overrun), 32'h1);
    check("s4.kept", 32'(dout), 32'h11);
    step(1'b0, 1'b0);
    check("s4.ovr_pulse", 32'(overrun), 32'h0);
    send_frame(8'h22, 1'b0, 0, 1);
    check("s4.no_ovr", 32'(overrun), 32'h0);
    check("s4.swap_v", 32'(dout_valid), 32'h1);
    check("s4.swap_d", 32'(dout), 32'h22);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // 5: bad stop bit, then a good frame
    send_frame(8'h5A, 1'b1, 0, 0);
    check("s5.ferr", 32'(frame_err), 32'h1);
    check("s5.valid", 32'(dout_valid), 32'h0);
    step(1'b0, 1'b0);
    check("s5.ferr_pulse", 32'(frame_err), 32'h0);
    step(1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 0, 0);
    check("s5.next", 32'(dout), 32'hC3);
    check("s5.next_v", 32'(dout_valid), 32'h1);
    step(1'b0, 1'b1);

    // 6: reset part-way through a frame
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    mid_reset("rst6");
    step(1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 0, 0);
    check("s6.word", 32'(dout), 32'h81);
    check("s6.valid", 32'(dout_valid), 32'h1);
    step(1'b0, 1'b1);

    // Random traffic: gaps, random ready, occasional bad stop bits
    ferr_seen = 0;
    ovr_seen  = 0;
    for (int f = 0; f < 200; f++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step(1'b0, logic'($urandom_range(0, 1)));
      send_frame(W'($urandom), ($urandom_range(0, 7) == 0), 2, 2);
      if (frame_err) ferr_seen++;
      if (overrun) ovr_seen++;
    end
    check("rand.exclusive", 32'(frame_err & overrun), 32'h0);

    $display("random frames: %0d framing errors, %0d overruns", ferr_seen, ovr_seen);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sipo_frame_rx.md
# sipo_frame_rx

Serial-to-parallel framed receiver: the far end of the single-bit serial link driven by the team's shift-register serializers. It watches the serial line for a start bit, shifts in a fixed-width data word MSB first, checks the stop bit, and presents the word on a parallel valid/ready interface. A one-entry holding register decouples frame arrival from the consumer; overrun and framing errors are flagged as single-cycle pulses.

## Interface

**Parameters**
- `WIDTH`, default 8: data bits per frame; legal range 2..32.

**Ports**
- `clk`, in, 1: single clock; all sampling on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `si`, in, 1: serial line in. Idle level is 0. Synchronous to `clk`; no internal synchronizer.
- `dout`, out, `WIDTH`: received word, valid while `dout_valid` = 1.
- `dout_valid`, out, 1: holding register is full.
- `dout_ready`, in, 1: consumer accepts `dout` on any edge where `dout_valid` and `dout_ready` are both 1.
- `frame_err`, out, 1: one-cycle pulse when a stop bit is bad.
- `overrun`, out, 1: one-cycle pulse when a good frame is dropped because the holding register is full.

## Operation

- Frame format: start bit = 1, then `WIDTH` data bits MSB first, then stop bit = 0. The frame is `WIDTH+2` bits, one bit per clock.
- State machine:
  - **IDLE**: on an edge with `si`=1, go to SHIFT and clear the bit counter. With `si`=0, stay in IDLE.
  - **SHIFT**: each edge does `shreg <= {shreg[WIDTH-2:0], si}` and increments the counter. After the `WIDTH`-th data bit, go to STOP.
  - **STOP**: sample `si` as the stop bit, then always return to IDLE.
- On the STOP edge:
  - Stop bit = 0 and the register is empty, or is being drained on this same edge: load `dout` <= `shreg`, set `dout_valid` = 1.
  - Stop bit = 0 and `dout_valid`=1 with `dout_ready`=0: drop the word. `dout` keeps its old value. Pulse `overrun` for one cycle.
  - Stop bit = 1: drop the word and pulse `frame_err` for one cycle. This bit is not treated as a new start bit.
- Handshake:
  - Acceptance with no simultaneous load clears `dout_valid` on that edge.
  - Acceptance and load on the same edge keep `dout_valid` = 1, with `dout` = the new word.
- `dout` holds its value while `dout_valid` = 1 and is stable until accepted. When `dout_valid` = 0 its value is don't-care, but the implementation holds the last word.
- `frame_err` and `overrun` are mutually exclusive.
- Reset (asynchronous, active-low):
  - State goes to IDLE; the counter and `shreg` clear.
  - `dout` = 0, `dout_valid` = 0, `frame_err` = 0, `overrun` = 0.
  - Assertion mid-frame abandons the frame. After release, the receiver hunts for a fresh start bit.
- Width rules:
  - The counter is `$clog2(WIDTH+1)` bits.
  - `shreg` is `WIDTH` bits; no other arithmetic.

## Timing

- Edges are numbered from the start-bit sample E0: data bits at E1..E`WIDTH`, stop bit at E(`WIDTH`+1).
- `dout_valid`, `frame_err` and `overrun` become visible right after E(`WIDTH`+1). Latency from start-bit sample to word is `WIDTH`+1 cycles.
- A back-to-back frame may have its start bit at E(`WIDTH`+2), giving a maximum throughput of one word per `WIDTH`+2 cycles.
- Error pulses are high for exactly one cycle and deassert at E(`WIDTH`+2).
- `dout_ready` may be held high continuously. It has no combinational path to any output.

## Test plan

All scenarios use `WIDTH`=8.

1. **Reset values.** Assert `rst`=0 mid-simulation, with `si` toggling → all outputs read 0 immediately, without waiting for `clk`. After release with `si`=0 for 20 cycles → `dout_valid` stays 0.
2. **Single frame.** Stream 1, 1010_0101, 0 with `dout_ready`=0 → after E9, `dout`=8'hA5, `dout_valid`=1, held indefinitely. Then pulse `dout_ready` for one cycle → `dout_valid`=0 on the next edge.
3. **Back-to-back with continuous ready.** Send frames 8'h3C then 8'hFF, no idle gap, `dout_ready`=1 → `dout_valid` pulses 1 cycle for each. `dout`=8'h3C after E9 and 8'hFF after E19; no error pulses.
4. **Overrun, plus simultaneous accept/load.**
   - Receive 8'h11 and leave it unaccepted, then receive 8'h22 → `overrun` pulses one cycle and `dout` stays 8'h11.
   - Repeat with `dout_ready`=1 exactly on the stop edge of 8'h22 → no overrun, `dout_valid` stays 1, `dout`=8'h22.
5. **Framing error.** Send 1, 8'h5A, stop=1, then `si`=0 → `frame_err` pulses one cycle after E9 and `dout_valid` stays 0. The stop bit does not start a frame; the next proper frame 8'hC3 is received correctly.
6. **Reset mid-frame.** Assert `rst` after 4 data bits of 8'hF0, release, then send a full 8'h81 frame → only 8'h81 is delivered and no error pulses occur.
